// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit path.
// Holds the arbiter FSM state encoding and the default byte width.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // One-hot state encoding for the transmit arbiter FSM.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'b0001,
        ST_START     = 4'b0010,
        ST_WAIT_DONE = 4'b0100,
        ST_GAP       = 4'b1000
    } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker.
// Returns the first set request bit found searching upward from
// last_grant+1, wrapping from NUM_REQ-1 back to 0.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    // Scan from the farthest candidate to the nearest so the nearest one wins.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx[IDX_W-1:0]]) begin
                grant = idx[IDX_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter
// between NUM_REQ byte requesters.
// Optional feature macro: UART_ARB_TIMEOUT_EN adds a watchdog on WAIT_DONE
// that pulses timeout_err and returns to IDLE after TIMEOUT_CYCLES clocks.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                          CLK100MHZ,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    // Gap counter runs 0..GAP_CYCLES-1 while in GAP.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_t              state_reg;
    logic [IDX_W-1:0]        last_grant_reg;
    logic [GAP_W-1:0]        gap_cnt_reg;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_valid;
    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant_reg),
        .grant      (sel_idx),
        .valid      (sel_valid)
    );

    assign busy = (state_reg != ST_IDLE);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_reg;
`else
    // No watchdog in this build; the limit parameter is intentionally unused.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_err        = 1'b0;
`endif

    // Arbiter FSM: grant in IDLE, launch in START, wait for the transmitter, optional gap.
    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= IDX_W'(NUM_REQ - 1);
            gap_cnt_reg    <= '0;
            tx_start       <= 1'b0;
            req_ack        <= '0;
            tx_data        <= '0;
            grant_id       <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_reg     <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            tx_start    <= 1'b0;
            req_ack     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            unique case (state_reg)
                ST_IDLE: begin
                    if (sel_valid) begin
                        tx_data        <= req_bytes[sel_idx];
                        grant_id       <= sel_idx;
                        last_grant_reg <= sel_idx;
                        req_ack        <= NUM_REQ'(1) << sel_idx;
                        state_reg      <= ST_START;
                    end
                end
                ST_START: begin
                    tx_start   <= 1'b1;
                    state_reg  <= ST_WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
                    to_cnt_reg <= '0;
`endif
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_reg <= '0;
                            state_reg   <= ST_GAP;
                        end else begin
                            state_reg   <= ST_IDLE;
                        end
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        to_cnt_reg  <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Directed phases (single request, spurious done, mid-transfer reset,
// fairness) followed by randomized requesters and a random-latency
// transmitter model; a separate monitor predicts grants and checks them.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int DW  = 8;
    localparam int NR  = 4;
    localparam int GAP = 3;
    localparam int IW  = 2;

    logic           clk      = 1'b0;
    logic           reset_n  = 1'b0;
    logic [NR-1:0]  req      = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_ack;
    logic           tx_start;
    logic [DW-1:0]  tx_data;
    logic           tx_done  = 1'b0;
    logic [IW-1:0]  grant_id;
    logic           busy;
    logic           timeout_err;

    // Marks a tx_done that ends a real transfer (as opposed to a spurious pulse).
    logic           done_real = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard queues: filled on each grant, drained on each tx_start.
    logic [DW-1:0]  byte_q[$];
    int             id_q[$];

    // Transmitter model state (owned by the stimulus process).
    bit in_xfer   = 1'b0;
    bit hold_done = 1'b0;
    int done_cnt  = 0;

    int order[$];

    uart_tx_arbiter #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (200000)
    ) dut (
        .CLK100MHZ   (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference rule: nearest requesting index after 'last', wrapping; -1 if none.
    function automatic int rr_model(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (r[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    // One clock of stimulus: transmitter model, requester protocol, optional randomness.
    task automatic tick(input bit rand_req, input bit rand_spur);
        @(posedge clk);
        #1;
        tx_done   = 1'b0;
        done_real = 1'b0;
        if (tx_start) begin
            in_xfer  = 1'b1;
            done_cnt = $urandom_range(0, 4);
        end
        if (in_xfer && !hold_done) begin
            if (done_cnt == 0) begin
                tx_done   = 1'b1;
                done_real = 1'b1;
                in_xfer   = 1'b0;
            end else begin
                done_cnt--;
            end
        end else if (!in_xfer && rand_spur && req_ack == '0 && $urandom_range(0, 7) == 0) begin
            tx_done = 1'b1;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ack[i]) begin
                req[i] = 1'b0;
            end else if (rand_req) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                end else if (req[i] && $urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || in_xfer || req_ack != '0) && n < 200) begin
            tick(1'b0, 1'b0);
            n++;
        end
        if (n >= 200) fail_now("idle_timeout");
    endtask

    // Monitor: predicts each grant from the sampled requests and checks timing/data.
    initial begin : monitor
        logic [NR-1:0]    req_seen;
        logic [NR*DW-1:0] data_seen;
        logic [DW-1:0]    exp_b;
        logic [DW-1:0]    cur_byte;
        int model_last;
        int exp_idx;
        int exp_id;
        int cur_id;
        int done_age;
        bit ack_last;
        req_seen   = '0;
        data_seen  = '0;
        exp_b      = '0;
        cur_byte   = '0;
        model_last = NR - 1;
        exp_idx    = 0;
        exp_id     = 0;
        cur_id     = 0;
        done_age   = -1;
        ack_last   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_outputs", {req_ack, tx_start, tx_data, grant_id, busy, timeout_err}, 64'd0);
                byte_q.delete();
                id_q.delete();
                model_last = NR - 1;
                done_age   = -1;
                ack_last   = 1'b0;
            end else begin
                if (done_age >= 0) done_age++;
                if (done_age >= 1 && done_age <= GAP) check("gap_busy", busy, 64'd1);
                if (done_age == GAP + 1) check("gap_idle", busy, 64'd0);
                if (req_ack != '0) begin
                    exp_idx = rr_model(req_seen, model_last);
                    check("ack_grant", req_ack, (exp_idx < 0) ? 64'd0 : (64'd1 << exp_idx));
                    check("ack_busy", busy, 64'd1);
                    if (done_age >= 0 && done_age < GAP + 2) fail_now("ack_early");
                    if (exp_idx >= 0) begin
                        byte_q.push_back(data_seen[exp_idx*DW +: DW]);
                        id_q.push_back(exp_idx);
                        model_last = exp_idx;
                    end
                end else if (done_age == GAP + 2 && req_seen != '0) begin
                    fail_now("ack_after_gap");
                end
                if (done_age >= GAP + 2) done_age = -1;
                if (tx_start) begin
                    if (!ack_last) fail_now("start_without_ack");
                    if (byte_q.size() == 0) begin
                        fail_now("start_queue_empty");
                    end else begin
                        exp_b  = byte_q.pop_front();
                        exp_id = id_q.pop_front();
                        check("start_data", tx_data, exp_b);
                        check("start_grant", grant_id, exp_id);
                        cur_byte = exp_b;
                        cur_id   = exp_id;
                        $display("txn id=%0d data=%02h t=%0t", exp_id, exp_b, $time);
                    end
                end else if (ack_last) begin
                    fail_now("start_missing");
                end
                if (done_real) begin
                    check("hold_data", tx_data, cur_byte);
                    check("hold_grant", grant_id, cur_id);
                    check("done_busy", busy, 64'd1);
                    done_age = 0;
                end
                ack_last = (req_ack != '0);
            end
            req_seen  = req;
            data_seen = req_data;
        end
    end

    // Stimulus sequence.
    initial begin : stimulus
        int n;
        int idx;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Single request from requester 2.
        tick(1'b0, 1'b0);
        req = 4'b0100;
        req_data[2*DW +: DW] = 8'hA5;
        tick(1'b0, 1'b0);
        check("single_ack", req_ack, 64'h4);
        tick(1'b0, 1'b0);
        check("single_start", tx_start, 64'd1);
        check("single_data", tx_data, 64'hA5);
        check("single_busy", busy, 64'd1);
        wait_idle();

        // Spurious tx_done while idle.
        tick(1'b0, 1'b0);
        tx_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0);
            check("spur_busy", busy, 64'd0);
            check("spur_start", tx_start, 64'd0);
            check("spur_ack", req_ack, 64'd0);
        end

        // Reset while waiting for the transmitter.
        req = 4'b0010;
        req_data[1*DW +: DW] = 8'h3C;
        hold_done = 1'b1;
        n = 0;
        while (!in_xfer && n < 10) begin
            tick(1'b0, 1'b0);
            n++;
        end
        if (!in_xfer) fail_now("mid_start_timeout");
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_ack", req_ack, 64'd0);
        check("rst_mid_start", tx_start, 64'd0);
        check("rst_mid_data", tx_data, 64'd0);
        check("rst_mid_grant", grant_id, 64'd0);
        check("rst_mid_busy", busy, 64'd0);
        check("rst_mid_timeout", timeout_err, 64'd0);
        hold_done = 1'b0;
        in_xfer   = 1'b0;
        req       = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Fairness: all requesters held, re-asserted after each ack.
        req = 4'b1111;
        for (int c = 0; c < 200 && order.size() < 5; c++) begin
            tick(1'b0, 1'b0);
            if (req_ack != '0) begin
                idx = -1;
                for (int b = 0; b < NR; b++) if (req_ack[b]) idx = b;
                order.push_back(idx);
            end else begin
                req = 4'b1111;
            end
        end
        if (order.size() < 5) begin
            fail_now("fair_timeout");
        end else begin
            for (int i = 0; i < 5; i++) check("fair_order", order[i], i % NR);
        end
        req = '0;
        wait_idle();

        // Randomized traffic with spurious done pulses.
        for (int c = 0; c < 3000; c++) tick(1'b1, 1'b1);
        req = '0;
        wait_idle();
        @(negedge clk);
        #1;
        check("queue_drained", byte_q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
